// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding the UART transmitter: bursty core writes in, one byte per
// frame out through a valid/ready handshake, with a sticky drop flag.
module uart_tx_queue #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [7:0]            wr_byte,
    output logic                  full,
    output logic                  tx_valid,
    output logic [7:0]            tx_byte,
    input  logic                  tx_ready,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    input  logic                  overflow_clear
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam int unsigned PW    = DEPTH_LOG2;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [CW-1:0] count_nxt;
    logic          push;
    logic          pop;

    assign push    = wr_en && !full;
    assign pop     = tx_valid && tx_ready;
    assign tx_byte = mem[rp];

    // Storage array is intentionally left out of reset.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wp] <= wr_byte;
        end
    end

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CW'(1);
        end else if (!push && pop) begin
            count_nxt = count - CW'(1);
        end
    end

    // full/tx_valid are registered copies decoded from the next count.
    always_ff @(posedge clock) begin
        if (reset) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            full     <= 1'b0;
            tx_valid <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wp <= wp + PW'(1);
            end
            if (pop) begin
                rp <= rp + PW'(1);
            end
            count    <= count_nxt;
            full     <= (count_nxt == CW'(DEPTH));
            tx_valid <= (count_nxt != '0);
            if (overflow_clear) begin
                overflow <= 1'b0;
            end else if (wr_en && full) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboard bench for uart_tx_queue: written bytes are queued as expected
// output and compared against tx_byte whenever the transmitter accepts one.
module tb_uart_tx_queue;

    localparam int unsigned DEPTH_LOG2 = 4;
    localparam int unsigned DEPTH      = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_byte = 8'h00;
    logic       full;
    logic       tx_valid;
    logic [7:0] tx_byte;
    logic       tx_ready = 1'b0;
    logic [4:0] count;
    logic       overflow;
    logic       overflow_clear = 1'b0;

    int checks = 0;
    int failures = 0;
    int m_count = 0;
    logic m_ovf = 1'b0;
    logic [7:0] exp_q [$];

    uart_tx_queue #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_byte(wr_byte),
        .full(full), .tx_valid(tx_valid), .tx_byte(tx_byte), .tx_ready(tx_ready),
        .count(count), .overflow(overflow), .overflow_clear(overflow_clear)
    );

    always #5 clock = ~clock;

    // Accepted bytes are checked mid-low-phase, after inputs have settled.
    always @(negedge clock) begin
        #2;
        if (!reset && tx_valid && tx_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL pop_order got=%02h exp=<queue empty>", tx_byte);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (tx_byte !== e) begin
                    failures++;
                    $display("FAIL pop_order got=%02h exp=%02h", tx_byte, e);
                end
            end
        end
    end

    // One clock cycle of stimulus; keeps the bench's own count/overflow model.
    task automatic cyc(input logic wr, input logic [7:0] b, input logic rdy, input logic clr);
        logic do_push, do_pop, drop;
        @(negedge clock);
        wr_en = wr; wr_byte = b; tx_ready = rdy; overflow_clear = clr;
        do_push = wr && (m_count < DEPTH);
        do_pop  = rdy && (m_count != 0);
        drop    = wr && (m_count == DEPTH);
        @(posedge clock);
        if (do_push) exp_q.push_back(b);
        m_count = m_count + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
        if (clr) m_ovf = 1'b0;
        else if (drop) m_ovf = 1'b1;
        #1;
        wr_en = 1'b0; tx_ready = 1'b0; overflow_clear = 1'b0;
    endtask

    // Reset with wr_en/tx_ready deliberately asserted to show they are ignored.
    task automatic do_reset(input int n);
        @(negedge clock);
        reset = 1'b1; wr_en = 1'b1; wr_byte = 8'hE7; tx_ready = 1'b1;
        repeat (n) @(posedge clock);
        @(negedge clock);
        reset = 1'b0; wr_en = 1'b0; tx_ready = 1'b0;
        exp_q.delete();
        m_count = 0;
        m_ovf = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        do_reset(3);
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", tx_valid); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        repeat (3) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (count !== 5'd0 || tx_valid !== 1'b0) begin
            failures++; $display("FAIL idle_ready count=%0d valid=%b exp=0/0", count, tx_valid);
        end
    endtask

    task automatic test_single;
        cyc(1'b1, 8'h41, 1'b0, 1'b0);
        checks++; if (tx_valid !== 1'b1 || tx_byte !== 8'h41 || count !== 5'd1) begin
            failures++; $display("FAIL single_visible valid=%b byte=%02h count=%0d exp=1/41/1", tx_valid, tx_byte, count);
        end
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 8'h00, 1'b0, 1'b0);
            checks++; if (tx_valid !== 1'b1 || tx_byte !== 8'h41) begin
                failures++; $display("FAIL single_hold cycle=%0d valid=%b byte=%02h exp=1/41", i, tx_valid, tx_byte);
            end
        end
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (count !== 5'd0 || tx_valid !== 1'b0) begin
            failures++; $display("FAIL single_pop count=%0d valid=%b exp=0/0", count, tx_valid);
        end
    endtask

    task automatic test_fill_wrap;
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
        checks++; if (full !== 1'b1 || count !== 5'd16) begin
            failures++; $display("FAIL fill_full full=%b count=%0d exp=1/16", full, count);
        end
        cyc(1'b1, 8'hAA, 1'b0, 1'b0);
        checks++; if (overflow !== 1'b1 || count !== 5'd16) begin
            failures++; $display("FAIL fill_drop overflow=%b count=%0d exp=1/16", overflow, count);
        end
        repeat (8) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (count !== 5'd8 || full !== 1'b0) begin
            failures++; $display("FAIL half_drain count=%0d full=%b exp=8/0", count, full);
        end
        for (int i = 16; i < 24; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
        checks++; if (full !== 1'b1 || count !== 5'd16) begin
            failures++; $display("FAIL wrap_full full=%b count=%0d exp=1/16", full, count);
        end
        repeat (16) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (count !== 5'd0 || tx_valid !== 1'b0 || exp_q.size() != 0) begin
            failures++; $display("FAIL wrap_drain count=%0d valid=%b left=%0d exp=0/0/0", count, tx_valid, exp_q.size());
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_simultaneous;
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 8'h40 + 8'(i), 1'b1, 1'b0);
            checks++; if (count !== 5'd3) begin
                failures++; $display("FAIL simul_count cycle=%0d got=%0d exp=3", i, count);
            end
        end
        for (int i = 0; i < 13; i++) cyc(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0);
        checks++; if (full !== 1'b1 || overflow !== 1'b0) begin
            failures++; $display("FAIL simul_full full=%b overflow=%b exp=1/0", full, overflow);
        end
        cyc(1'b1, 8'hEE, 1'b1, 1'b0);
        checks++; if (count !== 5'd15 || overflow !== 1'b1 || full !== 1'b0) begin
            failures++; $display("FAIL full_pushpop count=%0d overflow=%b full=%b exp=15/1/0", count, overflow, full);
        end
        repeat (15) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (count !== 5'd0 || exp_q.size() != 0) begin
            failures++; $display("FAIL simul_drain count=%0d left=%0d exp=0/0", count, exp_q.size());
        end
    endtask

    task automatic test_overflow;
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
        cyc(1'b1, 8'hCC, 1'b0, 1'b0);
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", overflow); end
        cyc(1'b1, 8'hBB, 1'b0, 1'b1);
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear_priority got=%b exp=0", overflow); end
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear_alone got=%b exp=0", overflow); end
        cyc(1'b1, 8'hDD, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 8'h00, 1'b0, 1'b0);
        checks++; if (overflow !== m_ovf || overflow !== 1'b1) begin
            failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow);
        end
        repeat (16) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL ovf_drain got=%0d exp=0", count); end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 9; i++) cyc(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0);
        checks++; if (count !== 5'd9 || overflow !== 1'b1) begin
            failures++; $display("FAIL mid_pre count=%0d overflow=%b exp=9/1", count, overflow);
        end
        do_reset(1);
        checks++; if (count !== 5'd0 || tx_valid !== 1'b0 || overflow !== 1'b0) begin
            failures++; $display("FAIL mid_reset count=%0d valid=%b overflow=%b exp=0/0/0", count, tx_valid, overflow);
        end
        cyc(1'b1, 8'h5A, 1'b0, 1'b0);
        checks++; if (tx_valid !== 1'b1 || tx_byte !== 8'h5A || count !== 5'd1) begin
            failures++; $display("FAIL mid_first valid=%b byte=%02h count=%0d exp=1/5A/1", tx_valid, tx_byte, count);
        end
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (tx_valid !== 1'b0 || exp_q.size() != 0) begin
            failures++; $display("FAIL mid_drain valid=%b left=%0d exp=0/0", tx_valid, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_wrap();
        test_simultaneous();
        test_overflow();
        test_reset_mid();
        repeat (3) @(posedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_queue.md
# uart_tx_queue

Byte FIFO that sits directly upstream of the UART transmitter. It decouples the core, which writes bytes in bursts at clock rate, from the transmitter, which consumes one byte per frame at baud rate. Bytes are held in arrival order and presented to the transmitter through a valid/ready handshake. Bytes written while the queue is full are dropped, and a sticky flag records the drop.

## Interface

Parameters:
- DEPTH_LOG2, default 4 — log2 of queue depth; DEPTH = 2**DEPTH_LOG2 (16 entries at default).

Ports:
- clock  in  1  — single clock for all logic.
- reset  in  1  — synchronous, active-high; clears all state on the clock edge where it is high.
- wr_en  in  1  — core write strobe; one byte offered per cycle where high.
- wr_byte  in  8  — byte to enqueue, sampled when wr_en is high.
- full  out  1  — high when count == DEPTH.
- tx_valid  out  1  — high when count != 0; head byte is on tx_byte.
- tx_byte  out  8  — head-of-queue byte; defined only while tx_valid is high.
- tx_ready  in  1  — transmitter accepts the head byte this cycle; pulsed once per byte when the transmitter enters its start-bit state.
- count  out  DEPTH_LOG2+1  — number of stored bytes, 0..DEPTH.
- overflow  out  1  — sticky; set when a write is dropped.
- overflow_clear  in  1  — clears overflow.

## Operation

- Storage: DEPTH x 8 register array. Write pointer wp and read pointer rp, each DEPTH_LOG2 bits. Count register is DEPTH_LOG2+1 bits.
- push = wr_en && !full. On push: mem[wp] <= wr_byte, wp <= wp + 1.
- pop = tx_valid && tx_ready. On pop: rp <= rp + 1.
- tx_ready while tx_valid is low is ignored: no pointer change, no error.
- Pointers wrap modulo DEPTH by natural overflow. There is no special case at DEPTH-1 -> 0.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop in the same cycle: unchanged; both pointers advance.
  - neither: unchanged.
- Full plus write: if wr_en is high while full, the byte is dropped and overflow <= 1. This holds even if a pop occurs in the same cycle; there is no write-through on full.
- Empty plus write: there is no bypass. A byte written into an empty queue appears on tx_valid/tx_byte the next cycle. tx_ready in the write cycle has no effect.
- Overflow flag:
  - overflow_clear has priority over setting in the same cycle: overflow <= 0.
  - Otherwise it is set by a dropped write and holds until cleared or reset.
- Ordering: strict FIFO. A byte is never duplicated or reordered.
- Reset:
  - On reset: wp = 0, rp = 0, count = 0, overflow = 0. Therefore tx_valid = 0 and full = 0.
  - Array contents are not reset. tx_byte is undefined after reset until the first write.
  - Reset mid-operation discards all queued bytes. wr_en and tx_ready are ignored during reset cycles.

## Timing

- full, tx_valid, count, overflow and tx_byte are functions of registers only. There is no combinational path from any input to any output.
- Write-to-visible latency is 1 cycle: wr_en high at edge N gives tx_valid high and tx_byte equal to that byte after edge N.
- Pop-to-next-head latency is 1 cycle: tx_byte shows the next entry after the accepting edge.
- While tx_valid is high and tx_ready is low, tx_byte and tx_valid are stable.
- Throughput: one push and one pop per cycle, sustained indefinitely when 0 < count < DEPTH.

## Test plan

- Reset then idle: hold reset 3 cycles, release -> count = 0, tx_valid = 0, full = 0, overflow = 0. tx_ready pulses cause no change.
- Single byte: write 8'h41 at cycle 0 -> tx_valid = 1, tx_byte = 8'h41, count = 1 at cycle 1. Hold tx_ready low 10 cycles -> tx_byte is held stable. Pulse tx_ready -> count = 0, tx_valid = 0.
- Fill and drain with wrap: write 0x00..0x0F (DEPTH 16) -> full = 1, count = 16. Write 0xAA -> dropped, overflow = 1. Pop 8, write 0x10..0x17, pop 16 -> exact sequence 0x00..0x17 with 0xAA absent. Pointers have wrapped.
- Simultaneous push/pop: with count = 3, assert wr_en and tx_ready together for 5 cycles -> count stays 3 and output order is preserved. At full with wr_en and tx_ready together -> write dropped, overflow set, count = 15.
- Overflow control: overflow_clear and a dropped write in the same cycle -> overflow = 0. overflow_clear alone later -> stays 0.
- Reset mid-operation: with count = 9, assert reset 1 cycle -> count = 0, tx_valid = 0, overflow = 0. A subsequent write of 8'h5A -> tx_byte = 8'h5A with no stale data before it.
